// File: rtl/alu_issue_arb_if.sv
// Issue-side bundle between the ALU requesters and the dual-pipe issue arbiter.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface alu_issue_arb_if #(
  parameter int NUM_REQ = 4
);
  logic                   flush_i;
  logic                   pipe1_en_i;
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ-1:0]     req_ready_o;
  logic [NUM_REQ*64-1:0]  req_op1_i;
  logic [NUM_REQ*64-1:0]  req_op2_i;
  logic [NUM_REQ*4-1:0]   req_ctrl_i;
  logic [NUM_REQ*7-1:0]   req_dest_i;
  logic [NUM_REQ*8-1:0]   req_rob_i;

  logic                   alu_valid0_o;
  logic                   alu_valid1_o;
  logic [63:0]            alu_op1_0_o;
  logic [63:0]            alu_op2_0_o;
  logic [63:0]            alu_op1_1_o;
  logic [63:0]            alu_op2_1_o;
  logic [3:0]             alu_ctrl_0_o;
  logic [3:0]             alu_ctrl_1_o;
  logic [6:0]             alu_dest_0_o;
  logic [6:0]             alu_dest_1_o;
  logic [7:0]             alu_rob_0_o;
  logic [7:0]             alu_rob_1_o;
  logic [31:0]            issue_cnt_o;

  modport slave (
    input  flush_i, pipe1_en_i, req_valid_i,
    input  req_op1_i, req_op2_i, req_ctrl_i, req_dest_i, req_rob_i,
    output req_ready_o,
    output alu_valid0_o, alu_valid1_o,
    output alu_op1_0_o, alu_op2_0_o, alu_op1_1_o, alu_op2_1_o,
    output alu_ctrl_0_o, alu_ctrl_1_o, alu_dest_0_o, alu_dest_1_o,
    output alu_rob_0_o, alu_rob_1_o, issue_cnt_o
  );

  modport master (
    output flush_i, pipe1_en_i, req_valid_i,
    output req_op1_i, req_op2_i, req_ctrl_i, req_dest_i, req_rob_i,
    input  req_ready_o,
    input  alu_valid0_o, alu_valid1_o,
    input  alu_op1_0_o, alu_op2_0_o, alu_op1_1_o, alu_op2_1_o,
    input  alu_ctrl_0_o, alu_ctrl_1_o, alu_dest_0_o, alu_dest_1_o,
    input  alu_rob_0_o, alu_rob_1_o, issue_cnt_o
  );
endinterface

// File: rtl/alu_issue_arb.sv
// Round-robin issue arbiter feeding two ALU pipes: up to two grants per cycle,
// payloads registered with one cycle of latency, running count of issued ops.
module alu_issue_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_arb_if.slave   bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef logic [PTR_W-1:0] idx_t;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  ctrl;
    logic [6:0]  dest;
    logic [7:0]  rob;
  } payload_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
    $error("alu_issue_arb: NUM_REQ must be a power of two in 2..8");
  end

  // ---------------------------------------------------------------------------
  // Unpack the flat request buses into one payload record per requester
  // ---------------------------------------------------------------------------
  payload_t req_pl [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_pl[g] = '{
      op1:  bus.req_op1_i [64*g +: 64],
      op2:  bus.req_op2_i [64*g +: 64],
      ctrl: bus.req_ctrl_i[4*g  +: 4],
      dest: bus.req_dest_i[7*g  +: 7],
      rob:  bus.req_rob_i [8*g  +: 8]
    };
  end

  // ---------------------------------------------------------------------------
  // Grant selection: scan from rr_ptr, first valid -> pipe 0, second -> pipe 1
  // ---------------------------------------------------------------------------
  idx_t               rr_ptr;
  idx_t               g0_idx;
  idx_t               g1_idx;
  logic               g0_hit;
  logic               g1_hit;
  logic               arb_en;
  logic [NUM_REQ-1:0] ready;

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin : p_select
    idx_t scan_idx;
    g0_hit   = 1'b0;
    g1_hit   = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_idx = '0;
    arb_en   = !rst && !bus.flush_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr + idx_t'(k);
      if (arb_en && bus.req_valid_i[scan_idx]) begin
        if (!g0_hit) begin
          g0_hit = 1'b1;
          g0_idx = scan_idx;
        end else if (bus.pipe1_en_i && !g1_hit) begin
          g1_hit = 1'b1;
          g1_idx = scan_idx;
        end
      end
    end
  end

  // Grants only ever land on valid requesters, so ready & valid == ready.
  always_comb begin : p_ready
    ready = '0;
    if (g0_hit) ready[g0_idx] = 1'b1;
    if (g1_hit) ready[g1_idx] = 1'b1;
  end

  assign bus.req_ready_o = ready;

  // ---------------------------------------------------------------------------
  // Issue registers, round-robin pointer and issue counter
  // ---------------------------------------------------------------------------
  payload_t    pipe0_q;
  payload_t    pipe1_q;
  logic        valid0_q;
  logic        valid1_q;
  logic [31:0] issue_cnt_q;

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  // NOTE: the payload registers are reset as well, because the outputs must
  // read zero while rst is held, not merely be flagged invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      issue_cnt_q <= '0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      pipe0_q     <= '0;
      pipe1_q     <= '0;
    end else begin
      // Flush is already folded into g*_hit, which clears both valids here.
      valid0_q <= g0_hit;
      valid1_q <= g1_hit;
      if (g0_hit) pipe0_q <= req_pl[g0_idx];
      if (g1_hit) pipe1_q <= req_pl[g1_idx];
      if (g0_hit) rr_ptr <= (g1_hit ? g1_idx : g0_idx) + idx_t'(1);
      issue_cnt_q <= issue_cnt_q + 32'(g0_hit) + 32'(g1_hit);
    end
  end

  assign bus.alu_valid0_o = valid0_q;
  assign bus.alu_valid1_o = valid1_q;
  assign bus.alu_op1_0_o  = pipe0_q.op1;
  assign bus.alu_op2_0_o  = pipe0_q.op2;
  assign bus.alu_ctrl_0_o = pipe0_q.ctrl;
  assign bus.alu_dest_0_o = pipe0_q.dest;
  assign bus.alu_rob_0_o  = pipe0_q.rob;
  assign bus.alu_op1_1_o  = pipe1_q.op1;
  assign bus.alu_op2_1_o  = pipe1_q.op2;
  assign bus.alu_ctrl_1_o = pipe1_q.ctrl;
  assign bus.alu_dest_1_o = pipe1_q.dest;
  assign bus.alu_rob_1_o  = pipe1_q.rob;
  assign bus.issue_cnt_o  = issue_cnt_q;

  // Structural guarantees of the grant logic.
  a_two_grants_max : assert property (@(posedge clk) disable iff (rst)
    $countones(bus.req_ready_o) <= 2);
  a_pipe1_needs_pipe0 : assert property (@(posedge clk) disable iff (rst)
    g1_hit |-> (g0_hit && g1_idx != g0_idx));

endmodule

// File: tb/tb_alu_issue_arb.sv
// Bench for alu_issue_arb: hand-derived grant table plus a scoreboard queue of
// expected pipe outputs, and sequences for async reset and starvation freedom.
module tb_alu_issue_arb;

  localparam int NR = 4;

  logic clk;
  logic rst;

  alu_issue_arb_if #(.NUM_REQ(NR)) bus ();

  alu_issue_arb #(.NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] valid;
    logic          p1;
    logic          flush;
    int            g0;   // expected pipe 0 grantee, -1 for none
    int            g1;   // expected pipe 1 grantee, -1 for none
  } vec_t;

  typedef struct {
    logic        v0, v1;
    logic [63:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;
    logic [6:0]  d0, d1;
    logic [7:0]  r0, r1;
    logic [31:0] cnt;
  } exp_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  exp_t        sb[$];
  exp_t        hold;
  logic [31:0] exp_cnt;

  logic [63:0] op1 [NR];
  logic [63:0] op2 [NR];
  logic [3:0]  ctl [NR];
  logic [6:0]  dst [NR];
  logic [7:0]  rob [NR];

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    hold    = '{default: '0};
    exp_cnt = '0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, " valid0"}, 64'(bus.alu_valid0_o), 64'(e.v0));
    check({tag, " valid1"}, 64'(bus.alu_valid1_o), 64'(e.v1));
    check({tag, " op1_0"},  bus.alu_op1_0_o,        e.a0);
    check({tag, " op2_0"},  bus.alu_op2_0_o,        e.b0);
    check({tag, " ctrl_0"}, 64'(bus.alu_ctrl_0_o),  64'(e.c0));
    check({tag, " dest_0"}, 64'(bus.alu_dest_0_o),  64'(e.d0));
    check({tag, " rob_0"},  64'(bus.alu_rob_0_o),   64'(e.r0));
    check({tag, " op1_1"},  bus.alu_op1_1_o,        e.a1);
    check({tag, " op2_1"},  bus.alu_op2_1_o,        e.b1);
    check({tag, " ctrl_1"}, 64'(bus.alu_ctrl_1_o),  64'(e.c1));
    check({tag, " dest_1"}, 64'(bus.alu_dest_1_o),  64'(e.d1));
    check({tag, " rob_1"},  64'(bus.alu_rob_1_o),   64'(e.r1));
    check({tag, " cnt"},    64'(bus.issue_cnt_o),   64'(e.cnt));
  endtask

  // One cycle: check last cycle's issue, drive new requests, check grants,
  // and queue the outputs they must produce after the next edge.
  task automatic apply(input logic [NR-1:0] valid, input logic p1, input logic flush,
                       input int g0, input int g1, input string tag);
    logic [NR-1:0] exp_ready;
    exp_t          e;
    @(negedge clk);
    pop_check(tag);
    for (int r = 0; r < NR; r++) begin
      op1[r] = {$urandom, $urandom};
      op2[r] = {$urandom, $urandom};
      ctl[r] = 4'($urandom);
      dst[r] = 7'($urandom);
      rob[r] = 8'($urandom);
      bus.req_op1_i[64*r +: 64] = op1[r];
      bus.req_op2_i[64*r +: 64] = op2[r];
      bus.req_ctrl_i[4*r +: 4]  = ctl[r];
      bus.req_dest_i[7*r +: 7]  = dst[r];
      bus.req_rob_i[8*r +: 8]   = rob[r];
    end
    bus.req_valid_i = valid;
    bus.pipe1_en_i  = p1;
    bus.flush_i     = flush;
    #1;
    exp_ready = '0;
    if (g0 >= 0) exp_ready[g0] = 1'b1;
    if (g1 >= 0) exp_ready[g1] = 1'b1;
    check({tag, " ready"}, 64'(bus.req_ready_o), 64'(exp_ready));

    e    = hold;
    e.v0 = (g0 >= 0);
    e.v1 = (g1 >= 0);
    if (g0 >= 0) begin
      e.a0 = op1[g0]; e.b0 = op2[g0]; e.c0 = ctl[g0]; e.d0 = dst[g0]; e.r0 = rob[g0];
      exp_cnt = exp_cnt + 1;
    end
    if (g1 >= 0) begin
      e.a1 = op1[g1]; e.b1 = op2[g1]; e.c1 = ctl[g1]; e.d1 = dst[g1]; e.r1 = rob[g1];
      exp_cnt = exp_cnt + 1;
    end
    e.cnt = exp_cnt;
    hold  = e;
    sb.push_back(e);
  endtask

  initial begin
    logic [NR-1:0] seen;

    // Grant table from reset (rr_ptr starts at 0); pointer noted after each row.
    vecs[0]  = '{4'b1111, 1'b1, 1'b0,  0,  1};  // ptr 2, cnt 2
    vecs[1]  = '{4'b1111, 1'b1, 1'b0,  2,  3};  // ptr 0
    vecs[2]  = '{4'b1111, 1'b1, 1'b0,  0,  1};  // ptr 2
    vecs[3]  = '{4'b1111, 1'b1, 1'b0,  2,  3};  // ptr 0, cnt 8
    vecs[4]  = '{4'b0100, 1'b1, 1'b0,  2, -1};  // ptr 3
    vecs[5]  = '{4'b1001, 1'b1, 1'b0,  3,  0};  // wraps, ptr 1
    vecs[6]  = '{4'b0110, 1'b0, 1'b0,  1, -1};  // pipe 1 disabled, ptr 2
    vecs[7]  = '{4'b0110, 1'b0, 1'b0,  2, -1};  // ptr 3
    vecs[8]  = '{4'b1111, 1'b1, 1'b1, -1, -1};  // flush: nothing, ptr stays 3
    vecs[9]  = '{4'b1111, 1'b1, 1'b0,  3,  0};  // ptr 1
    vecs[10] = '{4'b0000, 1'b1, 1'b0, -1, -1};  // idle, ptr 1
    vecs[11] = '{4'b1000, 1'b1, 1'b0,  3, -1};  // ptr 0
    vecs[12] = '{4'b0001, 1'b1, 1'b0,  0, -1};  // ptr 1
    vecs[13] = '{4'b1010, 1'b0, 1'b0,  1, -1};  // ptr 2
    vecs[14] = '{4'b1010, 1'b1, 1'b0,  3,  1};  // ptr 2
    vecs[15] = '{4'b0101, 1'b1, 1'b0,  2,  0};  // ptr 1

    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.pipe1_en_i  = 1'b0;
    bus.req_valid_i = '0;
    bus.req_op1_i   = '0;
    bus.req_op2_i   = '0;
    bus.req_ctrl_i  = '0;
    bus.req_dest_i  = '0;
    bus.req_rob_i   = '0;
    clear_model();

    // Reset state, with requests pending to show ready stays low under reset.
    repeat (2) @(negedge clk);
    bus.req_valid_i = 4'b1111;
    bus.pipe1_en_i  = 1'b1;
    #1;
    check("reset ready",  64'(bus.req_ready_o),  64'd0);
    check("reset valid0", 64'(bus.alu_valid0_o), 64'd0);
    check("reset valid1", 64'(bus.alu_valid1_o), 64'd0);
    check("reset cnt",    64'(bus.issue_cnt_o),  64'd0);
    check("reset op1_0",  bus.alu_op1_0_o,       64'd0);
    check("reset rob_1",  64'(bus.alu_rob_1_o),  64'd0);
    @(negedge clk);
    rst             = 1'b0;
    bus.req_valid_i = '0;

    for (int i = 0; i < 16; i++)
      apply(vecs[i].valid, vecs[i].p1, vecs[i].flush, vecs[i].g0, vecs[i].g1,
            $sformatf("vec%0d", i));
    apply('0, 1'b0, 1'b0, -1, -1, "drain");

    // Async reset mid-operation: build up cnt=5 with pipe 0 valid, then reset.
    @(negedge clk);
    pop_check("drain2");
    rst = 1'b1;
    #1;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1111, 1'b1, 1'b0, 0,  1, "pre_rst0");
    apply(4'b1111, 1'b1, 1'b0, 2,  3, "pre_rst1");
    apply(4'b0001, 1'b0, 1'b0, 0, -1, "pre_rst2");
    @(negedge clk);
    pop_check("pre_rst_out");
    bus.req_valid_i = 4'b1111;
    bus.pipe1_en_i  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async valid0", 64'(bus.alu_valid0_o), 64'd0);
    check("async valid1", 64'(bus.alu_valid1_o), 64'd0);
    check("async cnt",    64'(bus.issue_cnt_o),  64'd0);
    check("async op1_0",  bus.alu_op1_0_o,       64'd0);
    check("async ready",  64'(bus.req_ready_o),  64'd0);
    clear_model();
    @(negedge clk);
    rst             = 1'b0;
    bus.req_valid_i = '0;

    // First decision after reset uses rr_ptr=0; registered op was discarded.
    apply(4'b1111, 1'b0, 1'b0, 0, -1, "post_rst");   // ptr 1
    apply('0,      1'b0, 1'b0, -1, -1, "post_idle");

    // Starvation freedom: single-pipe, all valid, every requester within 4 cycles.
    seen = '0;
    for (int k = 0; k < NR; k++) begin
      apply(4'b1111, 1'b0, 1'b0, (1 + k) % NR, -1, $sformatf("starve%0d", k));
      seen |= bus.req_ready_o;
    end
    check("starvation coverage", 64'(seen), 64'(4'b1111));
    apply('0, 1'b0, 1'b0, -1, -1, "final");
    @(negedge clk);
    pop_check("final_out");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
